mem_arbiter: RTL

Parametrised N-channel memory arbiter. It lets the core's independent memory requesters (instruction fetch, data read, data write, and future DMA/debug ports) share one external memory bus. The arbiter grants one channel at a time, runs a single outstanding transaction on the memory side, and returns a one-cycle `resp_valid` pulse to the owning channel. It sits between the core's memory ports and the board-level memory controller.

---
 rtl/mem_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel, single-outstanding memory arbiter; round-robin when MEM_ARBITER_ROUND_ROBIN_EN is defined, else fixed priority
module mem_arbiter #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       req_enable,
    input  logic [CHANNELS-1:0]       req_write,
    input  logic [CHANNELS*WIDTH-1:0] req_address,
    input  logic [CHANNELS*WIDTH-1:0] req_wdata,
    output logic [CHANNELS-1:0]       resp_valid,
    output logic [WIDTH-1:0]          resp_data,
    output logic [WIDTH-1:0]          mem_address,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [WIDTH-1:0]          mem_wdata,
    input  logic                      mem_waitrequest,
    input  logic [WIDTH-1:0]          mem_rdata,
    input  logic                      mem_rdata_valid
);
    localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    state_t state, state_d;
    logic [IW-1:0] g, win;
    logic wr, cancel, abort, grant;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;
`endif
    assign grant = state == IDLE && |req_enable;
    assign abort = cancel | ~req_enable[g];
    // descending scan so the first requester in search order is the last to write win
    always_comb begin
        win = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (req_enable[(int'(ptr) + 1 + k) % CHANNELS]) win = IW'((int'(ptr) + 1 + k) % CHANNELS);
`else
            if (req_enable[k]) win = IW'(k);
`endif
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = grant ? ISSUE : IDLE;
            ISSUE:   state_d = mem_waitrequest ? ISSUE : !wr ? WAIT : abort ? IDLE : RESPOND;
            WAIT:    state_d = !mem_rdata_valid ? WAIT : abort ? IDLE : RESPOND;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        mem_read   = state == ISSUE && !wr;
        mem_write  = state == ISSUE && wr;
        resp_valid = state == RESPOND ? CHANNELS'(1) << g : '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            g           <= '0;
            wr          <= 1'b0;
            cancel      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            resp_data   <= '0;
        end else begin
            if (grant) begin
                g           <= win;
                wr          <= req_write[win];
                mem_address <= req_address[int'(win) * WIDTH +: WIDTH];
                mem_wdata   <= req_wdata[int'(win) * WIDTH +: WIDTH];
            end
            if (state == WAIT && mem_rdata_valid) resp_data <= mem_rdata;
            cancel <= state != IDLE && state_d != IDLE && abort;
        end
    end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) ptr <= IW'(CHANNELS - 1);
        else if (grant) ptr <= win;
`endif
endmodule
